// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with stall/bubble/flush control.
// Also preserves the madd/msub partial product and step count while EX is stalled.
module ex_mem_pipe #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ALUOP_W = 8,
  parameter int unsigned CNT_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                stall_ex,
  input  logic                stall_mem,
  input  logic [ADDR_W-1:0]   ex_dest_addr,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_dest_data,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [ALUOP_W-1:0]  ex_aluop,
  input  logic [DATA_W-1:0]   ex_mem_addr,
  input  logic [DATA_W-1:0]   ex_store_data,
  input  logic [2*DATA_W-1:0] ex_hilo_temp,
  input  logic [CNT_W-1:0]    ex_cnt,
  output logic [ADDR_W-1:0]   mem_dest_addr,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_dest_data,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic [ALUOP_W-1:0]  mem_aluop,
  output logic [DATA_W-1:0]   mem_mem_addr,
  output logic [DATA_W-1:0]   mem_store_data,
  output logic [2*DATA_W-1:0] hilo_temp_o,
  output logic [CNT_W-1:0]    cnt_o
);

  logic bubble;
  logic load;
  logic save_acc;

  // Flush wins over any stall; stall_mem without stall_ex is treated as a full hold.
  always_comb begin
    bubble   = flush | (stall_ex & ~stall_mem);
    load     = ~flush & ~stall_ex & ~stall_mem;
    save_acc = ~flush & stall_ex & ~stall_mem;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_dest_addr  <= '0;
      mem_wreg       <= 1'b0;
      mem_dest_data  <= '0;
      mem_whilo      <= 1'b0;
      mem_hi         <= '0;
      mem_lo         <= '0;
      mem_aluop      <= '0;
      mem_mem_addr   <= '0;
      mem_store_data <= '0;
    end else if (bubble) begin
      mem_dest_addr  <= '0;
      mem_wreg       <= 1'b0;
      mem_dest_data  <= '0;
      mem_whilo      <= 1'b0;
      mem_hi         <= '0;
      mem_lo         <= '0;
      mem_aluop      <= '0;
      mem_mem_addr   <= '0;
      mem_store_data <= '0;
    end else if (load) begin
      mem_dest_addr  <= ex_dest_addr;
      mem_wreg       <= ex_wreg;
      mem_dest_data  <= ex_dest_data;
      mem_whilo      <= ex_whilo;
      mem_hi         <= ex_hi;
      mem_lo         <= ex_lo;
      mem_aluop      <= ex_aluop;
      mem_mem_addr   <= ex_mem_addr;
      mem_store_data <= ex_store_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hilo_temp_o <= '0;
      cnt_o       <= '0;
    end else if (save_acc) begin
      hilo_temp_o <= ex_hilo_temp;
      cnt_o       <= ex_cnt;
    end else if (flush || load) begin
      hilo_temp_o <= '0;
      cnt_o       <= '0;
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: directed vector table, async-reset sequence and
// randomized traffic against a record-level reference model.
module tb_ex_mem_pipe;

  typedef struct packed {
    logic [4:0]  dest_addr;
    logic        wreg;
    logic [31:0] dest_data;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  aluop;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
  } fields_t;

  typedef struct {
    string       name;
    logic        flush;
    logic        stall_ex;
    logic        stall_mem;
    fields_t     in;
    logic [63:0] temp_in;
    logic [1:0]  cnt_in;
    fields_t     exp;
    logic [63:0] exp_temp;
    logic [1:0]  exp_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0, stall_ex = 1'b0, stall_mem = 1'b0;
  fields_t     in_f = '0;
  logic [63:0] temp_in = '0;
  logic [1:0]  cnt_in = '0;

  logic [4:0]  mem_dest_addr;
  logic        mem_wreg, mem_whilo;
  logic [31:0] mem_dest_data, mem_hi, mem_lo, mem_mem_addr, mem_store_data;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;
  fields_t     got_f;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ex_mem_pipe #(.ADDR_W(5), .DATA_W(32), .ALUOP_W(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .ex_dest_addr(in_f.dest_addr), .ex_wreg(in_f.wreg), .ex_dest_data(in_f.dest_data),
    .ex_whilo(in_f.whilo), .ex_hi(in_f.hi), .ex_lo(in_f.lo), .ex_aluop(in_f.aluop),
    .ex_mem_addr(in_f.mem_addr), .ex_store_data(in_f.store_data),
    .ex_hilo_temp(temp_in), .ex_cnt(cnt_in),
    .mem_dest_addr(mem_dest_addr), .mem_wreg(mem_wreg), .mem_dest_data(mem_dest_data),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_store_data(mem_store_data),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  assign got_f = {mem_dest_addr, mem_wreg, mem_dest_data, mem_whilo, mem_hi, mem_lo,
                  mem_aluop, mem_mem_addr, mem_store_data};

  function automatic fields_t rec(logic [4:0] a, logic w, logic [31:0] d, logic wh,
                                  logic [31:0] hi, logic [31:0] lo, logic [7:0] op,
                                  logic [31:0] ma, logic [31:0] sd);
    fields_t r;
    r = '{a, w, d, wh, hi, lo, op, ma, sd};
    return r;
  endfunction

  function automatic fields_t rand_rec();
    fields_t r;
    r = '{5'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
          8'($urandom), $urandom, $urandom};
    return r;
  endfunction

  task automatic check(input string name, input fields_t ef, input logic [63:0] et,
                       input logic [1:0] ec);
    vectors++;
    if (got_f !== ef || hilo_temp_o !== et || cnt_o !== ec) begin
      miscompares++;
      $display("FAIL %s: got fields=%h temp=%h cnt=%0d, expected fields=%h temp=%h cnt=%0d",
               name, got_f, hilo_temp_o, cnt_o, ef, et, ec);
    end
  endtask

  task automatic drive(input logic f, input logic se, input logic sm, input fields_t fi,
                       input logic [63:0] ti, input logic [1:0] ci);
    @(negedge clk);
    flush = f; stall_ex = se; stall_mem = sm; in_f = fi; temp_in = ti; cnt_in = ci;
    @(posedge clk);
    #1;
  endtask

  vec_t    tbl[$];
  fields_t ra, rb, rc, rd, re, rf, z;
  fields_t m;
  logic [63:0] mt;
  logic [1:0]  mc;

  initial begin
    z  = '0;
    ra = rec(5'd3, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 8'h21, 32'h0, 32'h0);
    rb = rec(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 8'hEB, 32'h100, 32'h55);
    rc = rec(5'd7, 1'b1, 32'h1111, 1'b1, 32'hAA, 32'hBB, 8'h2C, 32'h4, 32'h8);
    rd = rec(5'd9, 1'b1, 32'h2222_3333, 1'b0, 32'h0, 32'h0, 8'h25, 32'h0, 32'h0);
    re = rec(5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 8'hFF,
             32'hFFFF_FFFC, 32'hCAFE_F00D);
    rf = rec(5'd12, 1'b0, 32'h0BAD_0BAD, 1'b1, 32'h5, 32'h6, 8'h19, 32'h40, 32'h41);

    tbl.push_back('{"t1_pass",      0,0,0, ra, 64'hFFFF, 2'd3, ra, 64'h0, 2'd0});
    tbl.push_back('{"t6_store",     0,0,0, rb, 64'h0, 2'd0, rb, 64'h0, 2'd0});
    tbl.push_back('{"t3_madd_stall",0,1,0, rc, 64'h1_00000002, 2'd1, z, 64'h1_00000002, 2'd1});
    tbl.push_back('{"t3_release",   0,0,0, rd, 64'h77, 2'd2, rd, 64'h0, 2'd0});
    tbl.push_back('{"pass_e",       0,0,0, re, 64'h0, 2'd0, re, 64'h0, 2'd0});
    tbl.push_back('{"t4_hold1",     0,1,1, ra, 64'h1, 2'd1, re, 64'h0, 2'd0});
    tbl.push_back('{"t4_hold2",     0,1,1, rb, 64'h2, 2'd2, re, 64'h0, 2'd0});
    tbl.push_back('{"t4_hold3",     0,1,1, rc, 64'h3, 2'd3, re, 64'h0, 2'd0});
    tbl.push_back('{"stall_ex_save",0,1,0, rf, 64'h8000_0000_0000_0001, 2'd3, z,
                    64'h8000_0000_0000_0001, 2'd3});
    tbl.push_back('{"hold_saved",   0,1,1, ra, 64'h5, 2'd0, z, 64'h8000_0000_0000_0001, 2'd3});
    tbl.push_back('{"illegal_hold", 0,0,1, rb, 64'h6, 2'd1, z, 64'h8000_0000_0000_0001, 2'd3});
    tbl.push_back('{"pass_f",       0,0,0, rf, 64'h0, 2'd0, rf, 64'h0, 2'd0});
    tbl.push_back('{"t5_flush_hold",1,1,1, re, 64'h9, 2'd2, z, 64'h0, 2'd0});
    tbl.push_back('{"save_again",   0,1,0, rd, 64'hABCD, 2'd2, z, 64'hABCD, 2'd2});
    tbl.push_back('{"flush_nostall",1,0,0, re, 64'h9, 2'd1, z, 64'h0, 2'd0});
    tbl.push_back('{"flush_saved",  0,1,0, rc, 64'h1234, 2'd1, z, 64'h1234, 2'd1});
    tbl.push_back('{"flush_sex",    1,1,0, rc, 64'h4321, 2'd2, z, 64'h0, 2'd0});

    // Reset held across edges with busy inputs
    in_f = re; temp_in = 64'hFFFF; cnt_in = 2'd3; stall_ex = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("reset_state", z, 64'h0, 2'd0);
    @(negedge clk);
    rst = 1'b1; stall_ex = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].flush, tbl[i].stall_ex, tbl[i].stall_mem, tbl[i].in,
            tbl[i].temp_in, tbl[i].cnt_in);
      check(tbl[i].name, tbl[i].exp, tbl[i].exp_temp, tbl[i].exp_cnt);
    end

    // T2: async reset between edges, plus discard of saved madd state
    drive(0, 0, 0, re, 64'h0, 2'd0);
    drive(0, 1, 0, ra, 64'h55AA, 2'd2);
    check("pre_reset_saved", z, 64'h55AA, 2'd2);
    drive(0, 0, 0, re, 64'h0, 2'd0);
    check("pre_reset_pass", re, 64'h0, 2'd0);
    drive(0, 1, 0, rc, 64'hBEEF, 2'd3);
    flush = 0; stall_ex = 1; stall_mem = 1;
    #1 rst = 1'b0;
    #1 check("t2_async_clear", z, 64'h0, 2'd0);
    stall_ex = 0; stall_mem = 0; in_f = re;
    @(posedge clk);
    #1 check("t2_held_in_reset", z, 64'h0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, rb, 64'h0, 2'd0);
    check("post_reset_pass", rb, 64'h0, 2'd0);

    // Randomized traffic against a record-level model of the stage register
    m = rb; mt = '0; mc = '0;
    for (int n = 0; n < 400; n++) begin
      fields_t fi;
      logic [63:0] ti;
      logic [1:0] ci;
      logic f, se, sm;
      fi = rand_rec();
      ti = {$urandom, $urandom};
      ci = 2'($urandom);
      f  = ($urandom_range(0, 9) == 0);
      se = ($urandom_range(0, 2) == 0);
      sm = se ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      if (f) begin
        m = '0; mt = '0; mc = '0;
      end else if (se && !sm) begin
        m = '0; mt = ti; mc = ci;
      end else if (!se && !sm) begin
        m = fi; mt = '0; mc = '0;
      end
      drive(f, se, sm, fi, ti, ci);
      check("random", m, mt, mc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
